// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Sole producer of the register-file write port. It merges two write sources:
//   the in-order WB stage (source A, priority, never stalled) and a long-latency
//   unit (source B, buffered in a DEPTH-entry in-order FIFO). It also keeps a
//   32-bit pending scoreboard of registers still awaiting a source-B write, so
//   decode can stall on them.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   a_valid/a_reg/a_data       WB-stage write request
//   b_valid/b_reg/b_data       long-latency write request; b_ready = !full
//   rsv_valid/rsv_reg          decode reserves a destination of a long-latency op
//   chk_reg1/chk_reg2, stall   decode operand check against the pending set
//   fifo_count                 current FIFO occupancy (0..DEPTH)
//   RegWrite/Write_register/Write_data  registered register-file write port
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [4:0]       a_reg,
  input  logic [31:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_reg,
  input  logic [31:0]      b_data,
  input  logic             rsv_valid,
  input  logic [4:0]       rsv_reg,
  input  logic [4:0]       chk_reg1,
  input  logic [4:0]       chk_reg2,
  output logic             stall,
  output logic [PTR_W:0]   fifo_count,
  output logic             RegWrite,
  output logic [4:0]       Write_register,
  output logic [31:0]      Write_data
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_ent_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wr_ent_t          mem_q [DEPTH];
  wr_ent_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rw_q, rw_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pend_q, pend_d;

  logic    full, a_go, push, pop;
  wr_ent_t head;

  // Acceptance depends only on full: a pop on the same edge never frees a slot
  // for a push into a full FIFO.
  assign full    = (count_q == FULL_CNT);
  assign b_ready = !full;
  assign a_go    = a_valid && (a_reg != 5'd0);
  // $0 writes from B complete the handshake but are dropped here.
  assign push    = b_valid && !full && (b_reg != 5'd0);
  // Pop uses the pre-edge count, so an entry pushed into an empty FIFO waits a cycle.
  assign pop     = !a_go && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];

  assign stall          = pend_q[chk_reg1] | pend_q[chk_reg2];
  assign fifo_count     = count_q;
  assign RegWrite       = rw_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: b_reg, data: b_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output register: A wins, else FIFO head, else address/data hold.
  always_comb begin
    rw_d    = a_go || pop;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (a_go) begin
      wreg_d  = a_reg;
      wdata_d = a_data;
    end else if (pop) begin
      wreg_d  = head.rd;
      wdata_d = head.data;
    end
  end

  // Scoreboard: a B emission clears, a reservation sets; set is applied last so
  // it wins on a same-register collision. A writes never touch it.
  always_comb begin
    pend_d = pend_q;
    if (pop)       pend_d[head.rd] = 1'b0;
    if (rsv_valid) pend_d[rsv_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rw_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rw_q     <= rw_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
    end
  end

endmodule
